// File: rtl/axis_snoop_pkg.sv
// Shared types and helpers for the AXI-Stream snoop packet arbiter.
package axis_snoop_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  function automatic int ch_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/axis_snoop_pkt_fifo.sv
// Per-channel store-and-forward FIFO: captures snooped beats, exposes only
// committed packets, and drops whole packets that overflow.
module axis_snoop_pkt_fifo
  import axis_snoop_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cap_valid_i,
  input  logic [W-1:0]     cap_data_i,
  input  logic             cap_last_i,
  input  logic             rd_en_i,
  output logic             pkt_avail_o,
  output logic [W-1:0]     rd_data_o,
  output logic             rd_last_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             drop_pulse_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    commit_ptr_q, commit_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           dropping_q, dropping_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic           drop_pulse_q, drop_pulse_d;
  logic [W:0]     mem_q [DEPTH];
  logic           full_s;
  logic           wr_en_s;

  // Fullness uses the registered read pointer, so a same-cycle read never frees space.
  assign full_s      = ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH);
  assign pkt_avail_o = (commit_ptr_q != rd_ptr_q);
  assign {rd_last_o, rd_data_o} = mem_q[rd_ptr_q[AW-1:0]];
  assign drop_count_o = drop_cnt_q;
  assign drop_pulse_o = drop_pulse_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    dropping_d   = dropping_q;
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = 1'b0;
    wr_en_s      = 1'b0;
    rd_ptr_d     = (rd_en_i && pkt_avail_o) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (cap_valid_i) begin
      if (dropping_q || full_s) begin
        if (!dropping_q) begin
          wr_ptr_d = commit_ptr_q;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (cap_last_i) begin
          dropping_d   = 1'b0;
          drop_pulse_d = 1'b1;
          drop_cnt_d   = (drop_cnt_q == {CNT_W{1'b1}}) ? drop_cnt_q : (drop_cnt_q + CNT_W'(1));
        end else begin
          dropping_d = 1'b1;
        end
      end else begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (cap_last_i) begin
          commit_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          commit_ptr_d = commit_ptr_q;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      dropping_q   <= 1'b0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dropping_q   <= dropping_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  // Storage carries no reset; only committed entries are ever presented.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cap_last_i, cap_data_i};
    end
  end

endmodule

// File: rtl/axis_snoop_pkt_arb.sv
// N-channel AXI-Stream snoop arbiter: per-channel packet FIFOs feeding one
// master stream through a round-robin packet arbiter, tdest = source channel.
module axis_snoop_pkt_arb
  import axis_snoop_pkg::*;
#(
  parameter int NUM_INTERFACES = 4,
  parameter int PORT_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int DROP_CNT_WIDTH = 16,
  localparam int CH_WIDTH      = ch_width(NUM_INTERFACES)
) (
  input  logic                                     axis_aclk,
  input  logic                                     axis_aresetn,
  input  logic [NUM_INTERFACES-1:0]                s_axis_tvalid,
  input  logic [NUM_INTERFACES-1:0]                s_axis_tready,
  input  logic [NUM_INTERFACES*PORT_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_INTERFACES-1:0]                s_axis_tlast,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [PORT_WIDTH-1:0]                    m_axis_tdata,
  output logic                                     m_axis_tlast,
  output logic [CH_WIDTH-1:0]                      m_axis_tdest,
  output logic [NUM_INTERFACES*DROP_CNT_WIDTH-1:0] drop_count,
  output logic [NUM_INTERFACES-1:0]                drop_pulse
);

  arb_state_e              state_q, state_d;
  logic [CH_WIDTH-1:0]     grant_q, grant_d;
  logic [CH_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [NUM_INTERFACES-1:0] pkt_avail_s;
  logic [NUM_INTERFACES-1:0] rd_last_s;
  logic [NUM_INTERFACES-1:0] rd_en_s;
  logic [PORT_WIDTH-1:0]   rd_data_s [NUM_INTERFACES];
  logic                    sel_last_s;
  logic                    send_s;

  for (genvar g = 0; g < NUM_INTERFACES; g++) begin : g_ch
    assign rd_en_s[g] = send_s && (grant_q == CH_WIDTH'(g)) && m_axis_tready;

    axis_snoop_pkt_fifo #(
      .W     (PORT_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (DROP_CNT_WIDTH)
    ) u_fifo (
      .clk_i        (axis_aclk),
      .rst_ni       (axis_aresetn),
      .cap_valid_i  (s_axis_tvalid[g] & s_axis_tready[g]),
      .cap_data_i   (s_axis_tdata[g*PORT_WIDTH +: PORT_WIDTH]),
      .cap_last_i   (s_axis_tlast[g]),
      .rd_en_i      (rd_en_s[g]),
      .pkt_avail_o  (pkt_avail_s[g]),
      .rd_data_o    (rd_data_s[g]),
      .rd_last_o    (rd_last_s[g]),
      .drop_count_o (drop_count[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH]),
      .drop_pulse_o (drop_pulse[g])
    );
  end

  assign send_s        = (state_q == SEND);
  assign sel_last_s    = rd_last_s[grant_q];
  assign m_axis_tvalid = send_s;
  assign m_axis_tdata  = send_s ? rd_data_s[grant_q] : '0;
  assign m_axis_tlast  = send_s ? sel_last_s : 1'b0;
  assign m_axis_tdest  = send_s ? grant_q : '0;

  // Round-robin scan starts just after the last channel that finished a packet.
  always_comb begin
    logic found;
    int   cand;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    cand         = 0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_INTERFACES; k++) begin
          cand = (int'(last_grant_q) + k) % NUM_INTERFACES;
          if (!found && pkt_avail_s[cand]) begin
            found   = 1'b1;
            grant_d = CH_WIDTH'(cand);
          end else begin
            found = found;
          end
        end
        if (found) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (m_axis_tready && sel_last_s) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_WIDTH'(NUM_INTERFACES - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axis_snoop_pkt_arb.sv
// Randomised and directed bench for axis_snoop_pkt_arb against a packet-level
// scoreboard: short packets that fit must arrive intact, long ones are dropped.
module tb_axis_snoop_pkt_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     s_tvalid = '0;
  logic [N-1:0]     s_tready = '0;
  logic [N*W-1:0]   s_tdata = '0;
  logic [N-1:0]     s_tlast = '0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [W-1:0]     m_tdata;
  logic             m_tlast;
  logic [CHW-1:0]   m_tdest;
  logic [N*CW-1:0]  drop_count;
  logic [N-1:0]     drop_pulse;

  always #5 clk = ~clk;

  axis_snoop_pkt_arb #(
    .NUM_INTERFACES (N),
    .PORT_WIDTH     (W),
    .FIFO_DEPTH     (D),
    .DROP_CNT_WIDTH (CW)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdest  (m_tdest),
    .drop_count    (drop_count),
    .drop_pulse    (drop_pulse)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [8:0] exp_mem [N][1024];
  int head[N], tail[N], out_cnt[N], exp_drops[N], pulse_n[N], pulse_cyc[N], tlast_cyc[N];
  int st_dest[64], st_cyc[64];
  int st_n = 0;
  int hs_total = 0;
  bit active[N], longp[N];
  int plen[N], pidx[N];
  bit rnd_mode = 1'b0;
  bit mon_en = 1'b0;
  logic tready_val = 1'b1;

  task automatic chk_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic queue_pkt(input int c, input int len);
    active[c] = 1'b1;
    plen[c]   = len;
    pidx[c]   = 0;
    longp[c]  = (len > D);
  endtask

  function automatic bit any_active();
    for (int c = 0; c < N; c++) if (active[c]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus, driven 1 time unit after the rising edge.
  task automatic tick();
    logic [N-1:0]   tv, tr, tl;
    logic [N*W-1:0] td;
    logic [7:0]     d;
    int             r;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      d = 8'($urandom);
      td[c*W +: W] = d;
      if (active[c] && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
        tv[c] = 1'b1;
        tr[c] = 1'b1;
        tl[c] = (pidx[c] == plen[c] - 1);
        if (!longp[c]) begin
          exp_mem[c][tail[c] % 1024] = {tl[c], d};
          tail[c]++;
          out_cnt[c]++;
        end
        pidx[c]++;
        if (tl[c]) begin
          active[c]    = 1'b0;
          tlast_cyc[c] = cyc;
          if (longp[c]) exp_drops[c]++;
        end
      end else begin
        r     = rnd_mode ? $urandom_range(0, 2) : 2;
        tv[c] = (r == 2);
        tr[c] = (r == 1);
        tl[c] = 1'($urandom);
        if (rnd_mode && !active[c] && $urandom_range(0, 5) == 0) begin
          r = ($urandom_range(0, 11) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 6);
          if (r > D || out_cnt[c] + r <= D) queue_pkt(c, r);
        end
      end
    end
    s_tvalid = tv;
    s_tready = tr;
    s_tdata  = td;
    s_tlast  = tl;
    m_tready = rnd_mode ? ($urandom_range(0, 9) < 7) : tready_val;
  endtask

  task automatic run_pkts();
    int i = 0;
    while (any_active() && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) chk_eq("run_timeout", i, 0);
  endtask

  task automatic wait_drain();
    int pend;
    int i = 0;
    pend = 1;
    while (pend != 0 && i < 600) begin
      tick();
      i++;
      pend = int'(m_tvalid) + int'(any_active());
      for (int c = 0; c < N; c++) pend += tail[c] - head[c];
    end
    chk_eq("drain_pending", pend, 0);
  endtask

  // Output monitor, sampled on the falling edge.
  initial begin
    logic        hv;
    logic [11:0] hsnap;
    bit          open;
    int          pdest;
    int          c;
    hv = 1'b0;
    open = 1'b0;
    pdest = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        hv   = 1'b0;
        open = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (drop_pulse[k]) begin
            pulse_n[k]++;
            pulse_cyc[k] = cyc;
          end
        end
        if (hv) chk_eq("hold_stable", {m_tvalid, m_tlast, m_tdest, m_tdata}, hsnap);
        if (m_tvalid) begin
          if (!open) begin
            open  = 1'b1;
            pdest = int'(m_tdest);
            if (st_n < 64) begin
              st_dest[st_n] = pdest;
              st_cyc[st_n]  = cyc;
              st_n++;
            end
          end
          chk_eq("tdest_stable", m_tdest, pdest);
          if (m_tready) begin
            c = int'(m_tdest);
            if (tail[c] <= head[c]) begin
              chk_eq("sb_has_beat", tail[c] - head[c], 1);
            end else begin
              chk_eq("beat", {m_tlast, m_tdata}, exp_mem[c][head[c] % 1024]);
              head[c]++;
              out_cnt[c]--;
            end
            hs_total++;
            if (m_tlast) open = 1'b0;
          end
        end else begin
          chk_eq("idle_zero", {m_tlast, m_tdest, m_tdata}, 0);
        end
        hv    = m_tvalid && !m_tready;
        hsnap = {m_tvalid, m_tlast, m_tdest, m_tdata};
      end
    end
  end

  initial begin
    int hs0;
    int i;
    for (int c = 0; c < N; c++) begin
      head[c] = 0; tail[c] = 0; out_cnt[c] = 0; exp_drops[c] = 0;
      pulse_n[c] = 0; pulse_cyc[c] = 0; tlast_cyc[c] = 0;
      active[c] = 1'b0; longp[c] = 1'b0; plen[c] = 0; pidx[c] = 0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk_eq("rst_tvalid", m_tvalid, 0);
    chk_eq("rst_outputs", {m_tlast, m_tdest, m_tdata}, 0);
    chk_eq("rst_drop_pulse", drop_pulse, 0);
    chk_eq("rst_drop_count", drop_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single packet: data, tdest and first-valid latency.
    st_n = 0;
    queue_pkt(0, 3);
    run_pkts();
    wait_drain();
    chk_eq("t1_pkt_count", st_n, 1);
    chk_eq("t1_tdest", st_dest[0], 0);
    chk_eq("t1_latency", st_cyc[0] - tlast_cyc[0], 2);

    // Round robin: park last_grant on ch3, then 0/1/2 together, then 0/3 together.
    queue_pkt(3, 1);
    run_pkts();
    wait_drain();
    st_n = 0;
    queue_pkt(0, 2); queue_pkt(1, 2); queue_pkt(2, 2);
    run_pkts();
    wait_drain();
    chk_eq("t2_pkt_count", st_n, 3);
    chk_eq("t2_order0", st_dest[0], 0);
    chk_eq("t2_order1", st_dest[1], 1);
    chk_eq("t2_order2", st_dest[2], 2);
    chk_eq("t2_gap01", st_cyc[1] - st_cyc[0], 3);
    chk_eq("t2_gap12", st_cyc[2] - st_cyc[1], 3);
    st_n = 0;
    queue_pkt(0, 2); queue_pkt(3, 2);
    run_pkts();
    wait_drain();
    chk_eq("t2b_first", st_dest[0], 3);
    chk_eq("t2b_second", st_dest[1], 0);

    // Backpressure for five cycles after the first beat.
    queue_pkt(0, 3);
    i = 0;
    while (!m_tvalid && i < 20) begin
      tick();
      i++;
    end
    chk_eq("t3_valid_seen", m_tvalid, 1);
    hs0 = hs_total;
    tready_val = 1'b0;
    repeat (5) tick();
    chk_eq("t3_stall_hs", hs_total - hs0, 1);
    chk_eq("t3_held_valid", m_tvalid, 1);
    tready_val = 1'b1;
    wait_drain();

    // Oversized packet on ch1 is dropped, the following packet survives.
    queue_pkt(1, 20);
    run_pkts();
    repeat (3) tick();
    chk_eq("t4_drop_count", drop_count[1*CW +: CW], 1);
    chk_eq("t4_pulse_n", pulse_n[1], 1);
    chk_eq("t4_pulse_cyc", pulse_cyc[1] - tlast_cyc[1], 1);
    chk_eq("t4_no_output", m_tvalid, 0);
    queue_pkt(1, 3);
    run_pkts();
    wait_drain();

    // tvalid without tready on idle channels must not be captured.
    repeat (4) tick();
    queue_pkt(2, 2);
    run_pkts();
    wait_drain();

    // Random traffic with random downstream backpressure.
    rnd_mode = 1'b1;
    repeat (3000) tick();
    rnd_mode = 1'b0;
    run_pkts();
    wait_drain();
    for (int c = 0; c < N; c++) begin
      chk_eq("rnd_drop_count", drop_count[c*CW +: CW], exp_drops[c]);
      chk_eq("rnd_pulse_n", pulse_n[c], exp_drops[c]);
    end

    // Asynchronous reset in the middle of a stalled packet.
    queue_pkt(3, 5);
    run_pkts();
    tready_val = 1'b0;
    i = 0;
    while (!m_tvalid && i < 20) begin
      tick();
      i++;
    end
    chk_eq("t6_valid_seen", m_tvalid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_eq("t6_async_tvalid", m_tvalid, 0);
    chk_eq("t6_async_outputs", {m_tlast, m_tdest, m_tdata}, 0);
    for (int c = 0; c < N; c++) begin
      head[c] = 0; tail[c] = 0; out_cnt[c] = 0; exp_drops[c] = 0; pulse_n[c] = 0;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_eq("t6_drop_count", drop_count, 0);
    tready_val = 1'b1;
    hs0 = hs_total;
    repeat (5) tick();
    chk_eq("t6_fifos_empty", hs_total - hs0, 0);
    st_n = 0;
    queue_pkt(2, 2); queue_pkt(0, 2);
    run_pkts();
    wait_drain();
    chk_eq("t6_first_grant", st_dest[0], 0);
    chk_eq("t6_second_grant", st_dest[1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_snoop_pkt_arb.md
Name: axis_snoop_pkt_arb

Overview:
Parametrised N-channel AXI-Stream snoop arbiter. It passively captures packets from N snooped links, buffers each in a per-channel store-and-forward FIFO, and forwards only complete packets to one master stream. Channels are granted round-robin, and the source channel is tagged on tdest. Snoop inputs cannot be backpressured, so packets that overflow a FIFO are dropped whole and counted.

Parameters:
NUM_INTERFACES, 4, number of snooped channels (1..16)
PORT_WIDTH, 8, tdata width in bits
FIFO_DEPTH, 16, beats per channel FIFO (power of 2, >=4); largest packet deliverable
DROP_CNT_WIDTH, 16, width of each per-channel drop counter
CH_WIDTH (localparam), max(1, clog2(NUM_INTERFACES)), tdest width

Ports:
axis_aclk  in  1  clock; all logic on rising edge
axis_aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  NUM_INTERFACES  snooped tvalid per channel
s_axis_tready  in  NUM_INTERFACES  snooped tready per channel (observed, never driven)
s_axis_tdata  in  NUM_INTERFACES*PORT_WIDTH  snooped tdata; channel i at [i*PORT_WIDTH +: PORT_WIDTH]
s_axis_tlast  in  NUM_INTERFACES  snooped tlast
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  PORT_WIDTH  output data
m_axis_tlast  out  1  last beat of packet
m_axis_tdest  out  CH_WIDTH  source channel of current packet
drop_count  out  NUM_INTERFACES*DROP_CNT_WIDTH  saturating dropped-packet count per channel
drop_pulse  out  NUM_INTERFACES  one-cycle strobe per dropped packet

Behaviour:
- Reset (async assert, sync release):
  - Pointers, counters and drop state are 0; arbiter is IDLE; last_grant = NUM_INTERFACES-1, so ch0 wins first.
  - m_axis_tvalid, tlast, tdata, tdest are 0; drop_pulse is 0.
  - Partial packets are discarded and not counted.
- Capture:
  - A beat is captured on channel i only when s_axis_tvalid[i] && s_axis_tready[i]. tvalid without tready is ignored.
- Per-channel FIFO:
  - Pointers wr_ptr, commit_ptr, rd_ptr, each clog2(FIFO_DEPTH)+1 bits; wrap-around by natural overflow.
  - full = (wr_ptr - rd_ptr == FIFO_DEPTH), using the registered rd_ptr. A read in the same cycle does not free space for that cycle's write.
  - Captured beat, not full, not dropping: write at wr_ptr and increment wr_ptr. If tlast, commit_ptr <= wr_ptr+1.
  - Captured beat while full: wr_ptr <= commit_ptr (rewind) and enter DROP.
  - In DROP, all beats are discarded through the tlast beat inclusive. On that tlast: drop_count[i]++ (saturating at all-ones), drop_pulse[i]=1 for one cycle, exit DROP.
  - If the overflowing beat is itself tlast, the drop completes in that same cycle.
  - Packets longer than FIFO_DEPTH are always dropped.
- Packet available: pkt_avail[i] = (commit_ptr != rd_ptr). Only committed beats are ever read.
- Arbiter FSM:
  - IDLE: if any pkt_avail, grant the first available channel scanning last_grant+1, +2, ... (mod N). Register grant and go to SEND.
  - SEND: m_axis_tvalid=1, tdest=grant, tdata/tlast = FIFO[grant][rd_ptr] (combinational read). On tvalid&&tready, rd_ptr++. On a handshake with tlast: last_grant<=grant, go to IDLE.
  - Under m_axis_tready=0, tvalid, tdata, tlast and tdest hold stable.
- Latency:
  - tlast captured at edge k → pkt_avail from k → grant at edge k+1 → first output beat valid from edge k+1.
  - One IDLE bubble cycle between consecutive packets.
- Simultaneous write and read on the same channel are legal and independent.
- Outputs while IDLE: m_axis_tdata, tlast, tdest are forced to 0.

Decomposition:
- Package axis_snoop_pkg: arbiter state enum {IDLE, SEND} and a clog2-based CH_WIDTH helper function.
- Sub-module axis_snoop_pkt_fifo, one instance per channel:
  - Contains capture, commit/rewind, DROP state and drop counter.
  - Outputs pkt_avail, rd_data, rd_last.
  - Input rd_en.
- Top level holds the round-robin arbiter and the output mux.

Test Plan:
1. N=4, D=16. ch0 snoops {A0,A1,A2}, m_tready=1 → output A0,A1,A2; tlast on A2 only; tdest=0; first valid one edge after the A2 capture edge.
2. Packets complete on ch0, ch1 and ch2 in the same cycle → output order tdest 0,1,2 with one bubble between packets. Then packets complete on ch0 and ch3 after last_grant=2 → ch3 precedes ch0.
3. ch0 {D0,D1,D2}; m_tready=0 for 5 cycles after D0 handshake → D1 held stable with tvalid=1 throughout; D1,D2 then delivered, no loss or duplication.
4. ch1 snoops a 20-beat packet → nothing output for ch1, drop_count[1]=1, drop_pulse[1] high exactly on the tlast cycle. Next 3-beat packet {E0,E1,E2} on ch1 is delivered intact.
5. ch2 tvalid=1 with tready=0 for 4 cycles, then 2 beats with tready=1 (tlast on the second) → only the 2 beats are output.
6. aresetn driven low mid-SEND → m_axis_tvalid=0 immediately (asynchronous); after release all FIFOs are empty, drop_count=0, and the first grant goes to ch0.
